// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receive-byte handshake between the UART receiver FIFO and
// its consumer.
//   rx_data  : byte at the FIFO head (meaningful only while rx_valid=1)
//   rx_valid : FIFO holds at least one byte
//   rx_ready : consumer takes the head byte when rx_valid=1
// master = FIFO side (drives data/valid), slave = consumer side (drives ready).
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver with a show-ahead receive FIFO.
// The serial line is synchronised and each bit is majority-voted from three
// samples around its centre. Good frames are pushed into the FIFO; frames with
// a low stop bit raise a one-cycle frame_err and are dropped.
// Ports:
//   clk48      : fabric clock
//   rst_n      : asynchronous active-low reset
//   rx_serial  : asynchronous serial input, idle high
//   rx         : byte handshake (rx_data / rx_valid / rx_ready)
//   rx_busy    : receiver is in the middle of a frame or a line break
//   frame_err  : one-cycle pulse when a stop bit was sampled low
//   overflow   : sticky, a received byte was dropped because the FIFO was full
//   ovf_clear  : clears overflow (a new overflow in the same cycle wins)
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 416,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                  clk48,
  input  logic                  rst_n,
  input  logic                  rx_serial,
  uart_rx_fifo_if.master        rx,
  output logic                  rx_busy,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  ovf_clear
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned H  = CLKS_PER_BIT / 2;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(H - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(H);
  localparam logic [CW-1:0] CNT_DEC  = CW'(H + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser and start-edge qualification
  // ---------------------------------------------------------------------------
  logic [1:0] sync_q;
  logic [1:0] seed_q;
  logic       armed_q;
  logic       rxs_prev_q;
  logic       rxs;

  assign rxs = sync_q[1];

  // The synchroniser resets to 1, so a line held low across reset release
  // would otherwise look like a falling edge. seed_q marks when rxs carries a
  // real sample; start edges are accepted only after the line has been seen
  // high through the synchroniser.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '1;
      seed_q     <= '0;
      armed_q    <= 1'b0;
      rxs_prev_q <= 1'b1;
    end else begin
      sync_q     <= {sync_q[0], rx_serial};
      seed_q     <= {seed_q[0], 1'b1};
      armed_q    <= armed_q | (seed_q[1] & rxs);
      rxs_prev_q <= rxs;
    end
  end

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          s0_q, s0_d;
  logic          s1_q, s1_d;
  logic          frame_err_q, frame_err_d;
  logic          push;
  logic          maj;
  logic          decide;

  assign maj    = (s0_q & s1_q) | (s0_q & rxs) | (s1_q & rxs);
  assign decide = (cnt_q == CNT_DEC);

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      s0_q        <= 1'b1;
      s1_q        <= 1'b1;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      s0_q        <= s0_d;
      s1_q        <= s1_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    s0_d        = s0_q;
    s1_d        = s1_q;
    frame_err_d = 1'b0;
    push        = 1'b0;

    // Bit timer and the two early vote samples run in every in-frame state.
    if ((state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP)) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
      if (cnt_q == CNT_S0) s0_d = rxs;
      if (cnt_q == CNT_S1) s1_d = rxs;
    end

    unique case (state_q)
      S_IDLE: begin
        if (armed_q && rxs_prev_q && !rxs) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (decide) begin
          if (maj) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          shreg_d = {maj, shreg_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        // Returning to IDLE at mid-stop leaves half a bit to catch the next
        // start edge of a back-to-back frame.
        if (decide) begin
          if (maj) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_busy   = (state_q != S_IDLE);
  assign frame_err = frame_err_q;

  // ---------------------------------------------------------------------------
  // Show-ahead receive FIFO
  // ---------------------------------------------------------------------------
  logic [AW:0] wr_q, rd_q;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic        overflow_q;
  logic        empty;
  logic        full;
  logic        pop;
  logic        wr_en;
  logic        ovf_set;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop     = !empty && rx.rx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO only
  // fails when nothing leaves.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;

  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      wr_q       <= '0;
      rd_q       <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_q <= wr_q + (AW+1)'(1);
      if (pop)   rd_q <= rd_q + (AW+1)'(1);
      if (ovf_set) begin
        overflow_q <= 1'b1;
      end else if (ovf_clear) begin
        overflow_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk48) begin
    if (wr_en) mem_q[wr_q[AW-1:0]] <= shreg_q;
  end

  // Storage is not reset; the head is forced to zero while empty so rx_data
  // reads 0 out of reset.
  assign rx.rx_data  = empty ? '0 : mem_q[rd_q[AW-1:0]];
  assign rx.rx_valid = !empty;
  assign overflow    = overflow_q;

endmodule
